mips_boot_ctrl: RTL and testbench
=================================

// Module: mips_boot_ctrl
// PURPOSE
//  Upstream companion of mips_dpu. Streams a program image over a valid/ready port into instruction memory
//  while holding the core in reset, then releases the core, counts execution clocks and detects halt.
//  A halt is a branch-to-self: cpu_pc is unchanged for HALT_CYC consecutive cycles.
//  Replaces hand-timed bench delays with a measured run_cycles and a done flag.
// PARAMETERS
//  ADDR_W    8     imem word-address width; max image = 2**ADDR_W words
//  HALT_CYC  4     consecutive equal cpu_pc samples that declare a halt (>=2)
//  MAX_RUN   4096  run-cycle timeout; reaching it forces HALTED with timeout=1
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-low reset
//  start       in   1         1-cycle pulse; honoured only in IDLE or HALTED
//  load_len    in   ADDR_W+1  words to load, latched on start; 0 = run the existing image
//  in_valid    in   1         image word valid
//  in_data     in   32        image word
//  in_ready    out  1         loader accepts a word
//  imem_we     out  1         instruction-memory write strobe
//  imem_waddr  out  ADDR_W    word address
//  imem_wdata  out  32        write data
//  cpu_pc      in   32        pc_current from mips_dpu
//  cpu_reset   out  1         active-high reset driven to mips_dpu
//  busy        out  1         state is LOAD, PRST or RUN
//  done        out  1         state is HALTED
//  timeout     out  1         HALTED was reached by MAX_RUN, not by halt detection
//  run_cycles  out  32        clocks spent in RUN with cpu_reset low
// BEHAVIOUR
//  All outputs are registered.
//  Reset asserted (async): state=IDLE, cpu_reset=1, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0,
//   done=0, timeout=0, run_cycles=0, word count=0. In-flight load or run is abandoned; no partial write commits.
//  States: IDLE, LOAD, PRST, RUN, HALTED. cpu_reset=1 in IDLE/LOAD/PRST, 0 in RUN/HALTED.
//  IDLE/HALTED + start: latch len = min(load_len, 2**ADDR_W); clear done, timeout, run_cycles, count;
//   set cpu_reset=1. If len!=0 go to LOAD, else go to PRST.
//   start in any other state is ignored.
//  LOAD: in_ready=1. On in_valid&&in_ready at edge E: imem_we=1, imem_waddr=count, imem_wdata=in_data
//   for one cycle after E; count++. in_valid low means no write and no count change (stalls are unbounded).
//   On the handshake of word len-1: in_ready=0 after E; go to PRST.
//  PRST: exactly one cycle with cpu_reset=1 (the last imem write commits here), then go to RUN.
//   cpu_reset=0 from the following edge.
//  RUN: run_cycles++ every clock while cpu_reset=0.
//   Halt detect: register prev_pc. An equal compare increments stable; an unequal compare clears it to 0.
//   The first compare after cpu_reset falls is skipped.
//   stable reaching HALT_CYC-1 -> HALTED (timeout=0). run_cycles includes the spin cycles.
//   run_cycles reaching MAX_RUN -> HALTED (timeout=1). Halt and timeout on the same edge -> timeout=0.
//  HALTED: done=1; run_cycles frozen; cpu_reset held 0 so the core keeps its register file.
//  run_cycles saturates at 2**32-1. The address wraps never occur because len is clamped.
// TESTING
//  1. Reset low mid-LOAD after 3 of 8 words -> imem_we=0 immediately; cpu_reset=1, in_ready=0,
//     state IDLE; release and restart -> writes begin again at addr 0.
//  2. start, load_len=3, words 0xA,0xB,0xC with in_valid gaps of 2 cycles -> exactly 3 imem_we pulses
//     at addr 0,1,2 with matching data; cpu_reset falls 2 edges after the 3rd handshake.
//  3. After load, cpu_pc model steps 0,4,8,...,0x3C then sticks at 0x3C -> done after HALT_CYC-1 equal
//     compares; run_cycles = 16+HALT_CYC-1; timeout=0.
//  4. cpu_pc keeps incrementing, MAX_RUN=64 -> HALTED at run_cycles=64, timeout=1, cpu_reset stays 0.
//  5. From HALTED, start with load_len=0 -> one PRST cycle with cpu_reset=1, no imem_we, run_cycles
//     cleared; the run repeats with the same count. start pulsed during RUN is ignored.
//  6. load_len=2**ADDR_W+5 -> exactly 2**ADDR_W writes with the last at addr 2**ADDR_W-1; in_ready=0 afterwards.

Source files
------------

// File: rtl/mips_boot_ctrl.sv
// Boot controller for mips_dpu: streams a program image into instruction memory
// with the core held in reset, then releases it, counts run clocks and detects a halt.
module mips_boot_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int HALT_CYC = 4,
    parameter int MAX_RUN  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       cpu_pc,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       run_cycles
);

    localparam int                SW          = $clog2(HALT_CYC + 1);
    localparam logic [ADDR_W:0]   IMAGE_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [SW-1:0]     STABLE_HALT = SW'(HALT_CYC - 1);
    localparam logic [31:0]       RUN_LIMIT   = 32'(MAX_RUN);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRST, S_RUN, S_HALTED} state_t;

    state_t          state, state_next;
    logic [ADDR_W:0] len, count, len_clamped;
    logic [SW-1:0]   stable, stable_next;
    logic [31:0]     pc_p1, run_next;
    logic            skip_cmp;
    logic            start_ok, hs, last_word, counting, halt_hit, tmo_hit;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_next  = state;
        start_ok    = start && (state == S_IDLE || state == S_HALTED);
        hs          = (state == S_LOAD) && in_valid && in_ready;
        last_word   = hs && (count == len - 1'b1);
        counting    = (state == S_RUN) && !cpu_reset;
        len_clamped = (load_len > IMAGE_MAX) ? IMAGE_MAX : load_len;
        stable_next = stable;
        // The compare against the pc held before reset fell is meaningless, so skip it.
        if (counting && !skip_cmp)
            stable_next = (cpu_pc == pc_p1) ? stable + 1'b1 : '0;
        run_next = counting ? sat_inc(run_cycles) : run_cycles;
        halt_hit = counting && (stable_next == STABLE_HALT);
        tmo_hit  = counting && (run_next == RUN_LIMIT);
        case (state)
            S_IDLE, S_HALTED: if (start_ok) state_next = (len_clamped != '0) ? S_LOAD : S_PRST;
            S_LOAD:           if (last_word) state_next = S_PRST;
            S_PRST:           state_next = S_RUN;
            S_RUN:            if (halt_hit || tmo_hit) state_next = S_HALTED;
            default:          state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_reset  <= 1'b1;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            run_cycles <= '0;
            count      <= '0;
            len        <= '0;
            stable     <= '0;
            skip_cmp   <= 1'b1;
            pc_p1      <= '0;
        end else begin
            busy     <= state_next inside {S_LOAD, S_PRST, S_RUN};
            done     <= (state_next == S_HALTED);
            in_ready <= (state_next == S_LOAD);
            imem_we  <= hs;
            if (hs) begin
                imem_waddr <= count[ADDR_W-1:0];
                imem_wdata <= in_data;
                count      <= count + 1'b1;
            end
            if (start_ok) begin
                len        <= len_clamped;
                count      <= '0;
                run_cycles <= '0;
                timeout    <= 1'b0;
                cpu_reset  <= 1'b1;
            end else begin
                // cpu_reset drops one cycle after entering RUN and stays low through HALTED.
                if (state == S_RUN) cpu_reset <= 1'b0;
                run_cycles <= run_next;
                if (state == S_RUN && state_next == S_HALTED)
                    timeout <= tmo_hit && !halt_hit;
            end
            stable   <= counting ? stable_next : '0;
            skip_cmp <= !counting;
            pc_p1    <= cpu_pc;
        end
    end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Randomized self-checking bench for mips_boot_ctrl with a pc-trace reference model
// for halt/timeout and an image scoreboard for the loader.
module tb_mips_boot_ctrl;
    localparam int ADDR_W = 8, HALT_CYC = 4, MAX_RUN = 64, IMG = 1 << ADDR_W;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [ADDR_W:0] load_len = '0;
    logic [31:0] in_data = '0, cpu_pc = '0, stick_pc = '0;
    logic in_ready, imem_we, cpu_reset, busy, done, timeout;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0] imem_wdata, run_cycles;

    int n_cmp = 0, n_err = 0;
    int wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    mips_boot_ctrl #(.ADDR_W(ADDR_W), .HALT_CYC(HALT_CYC), .MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_pc(cpu_pc), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Core stand-in: pc walks by 4 until it reaches stick_pc, then branches to itself.
    always @(posedge clk) begin
        if (cpu_reset) cpu_pc <= '0;
        else if (cpu_pc < stick_pc) cpu_pc <= cpu_pc + 32'd4;
    end

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_waddr));
            wr_data_q.push_back(imem_wdata);
        end
    end

    // Halt = HALT_CYC identical consecutive pc samples; otherwise the MAX_RUN limit.
    function automatic void model_run(input longint stick, output int cyc, output bit tmo);
        longint prev, pc;
        int streak;
        prev = -1; streak = 0; cyc = MAX_RUN; tmo = 1'b1;
        for (int k = 0; k < MAX_RUN; k++) begin
            pc = (longint'(4 * k) < stick) ? longint'(4 * k) : stick;
            streak = (pc == prev) ? streak + 1 : 1;
            prev = pc;
            if (streak >= HALT_CYC) begin cyc = k + 1; tmo = 1'b0; return; end
        end
    endfunction

    task automatic do_start(input int len);
        load_len = (ADDR_W+1)'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 1000; t++) begin
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++; n_err++;
        $display("FAIL handshake_wait: in_ready stayed %0b, required 1", in_ready);
    endtask

    task automatic wait_done();
        for (int t = 0; t < MAX_RUN + 20 && !done; t++) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        n_cmp++; if ({cpu_reset, in_ready, imem_we, busy, done, timeout} !== 6'b100000) begin
            n_err++; $display("FAIL reset_ctrl: got %b required 100000", {cpu_reset, in_ready, imem_we, busy, done, timeout}); end
        n_cmp++; if (imem_waddr !== '0 || imem_wdata !== '0 || run_cycles !== '0) begin
            n_err++; $display("FAIL reset_data: addr %0h data %0h run %0d required 0", imem_waddr, imem_wdata, run_cycles); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (cpu_reset !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: cpu_reset %b busy %b required 1 0", cpu_reset, busy); end
    endtask

    task automatic test_mid_load_reset();
        int cyc; bit tmo;
        stick_pc = 32'h3C;
        do_start(8);
        for (int i = 0; i < 3; i++) send_word(32'h100 + i, i);
        n_cmp++; if (imem_we !== 1'b1) begin n_err++; $display("FAIL third_write: imem_we %b required 1", imem_we); end
        in_valid = 1'b1; in_data = 32'hDEAD;
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({imem_we, cpu_reset, in_ready, busy} !== 4'b0100) begin
            n_err++; $display("FAIL async_abort: we/cpu_reset/ready/busy %b required 0100", {imem_we, cpu_reset, in_ready, busy}); end
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(2);
        send_word(32'h55, 0); send_word(32'h66, 1);
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_addr_q.size() != 2 || wr_addr_q[0] != 0 || wr_addr_q[1] != 1) begin
            n_err++; $display("FAIL restart_addr: %0d writes first addr %0d required 2 writes from 0", wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : -1); end
        wait_done();
        model_run(longint'(stick_pc), cyc, tmo);
        n_cmp++; if (done !== 1'b1 || run_cycles !== 32'(cyc)) begin
            n_err++; $display("FAIL restart_run: done %b run %0d required 1 %0d", done, run_cycles, cyc); end
    endtask

    task automatic test_gapped_load();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
        stick_pc = 32'h3C;
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(3);
        for (int i = 0; i < 3; i++) send_word(exp_d[i], 2);
        n_cmp++; if (cpu_reset !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL after_last_hs: cpu_reset %b in_ready %b required 1 0", cpu_reset, in_ready); end
        @(negedge clk);
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL edge1_reset: cpu_reset %b required 1", cpu_reset); end
        @(negedge clk);
        n_cmp++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL edge2_reset: cpu_reset %b required 0", cpu_reset); end
        n_cmp++; if (wr_addr_q.size() != 3) begin
            n_err++; $display("FAIL gapped_count: %0d writes required 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            n_cmp++; if (wr_addr_q[i] != i || wr_data_q[i] !== exp_d[i]) begin
                n_err++; $display("FAIL gapped_write%0d: addr %0d data %0h required %0d %0h", i, wr_addr_q[i], wr_data_q[i], i, exp_d[i]); end
        end
    endtask

    task automatic test_halt_detect();
        int cyc; bit tmo;
        model_run(64'h3C, cyc, tmo);
        wait_done();
        n_cmp++; if (done !== 1'b1 || run_cycles !== 32'(16 + HALT_CYC - 1)) begin
            n_err++; $display("FAIL halt_cycles: done %b run %0d required 1 %0d", done, run_cycles, 16 + HALT_CYC - 1); end
        n_cmp++; if (timeout !== tmo || cpu_reset !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL halt_flags: timeout %b cpu_reset %b busy %b required %b 0 0", timeout, cpu_reset, busy, tmo); end
    endtask

    task automatic test_timeout();
        stick_pc = 32'hFFFF_FFF0;
        do_start(1);
        send_word(32'h1234, 0);
        wait_done();
        n_cmp++; if (done !== 1'b1 || run_cycles !== 32'(MAX_RUN) || timeout !== 1'b1) begin
            n_err++; $display("FAIL timeout_run: done %b run %0d timeout %b required 1 %0d 1", done, run_cycles, timeout, MAX_RUN); end
        repeat (3) @(negedge clk);
        n_cmp++; if (run_cycles !== 32'(MAX_RUN) || cpu_reset !== 1'b0 || done !== 1'b1) begin
            n_err++; $display("FAIL halted_hold: run %0d cpu_reset %b done %b required %0d 0 1", run_cycles, cpu_reset, done, MAX_RUN); end
    endtask

    task automatic test_rerun();
        int first_cnt;
        stick_pc = 32'h3C;
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(0);
        n_cmp++; if ({cpu_reset, busy, done, timeout, imem_we} !== 5'b11000 || run_cycles !== '0) begin
            n_err++; $display("FAIL rerun_prst: flags %b run %0d required 11000 0", {cpu_reset, busy, done, timeout, imem_we}, run_cycles); end
        @(negedge clk);
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rerun_edge1: cpu_reset %b required 1", cpu_reset); end
        @(negedge clk);
        n_cmp++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL rerun_edge2: cpu_reset %b required 0", cpu_reset); end
        repeat (2) @(negedge clk);
        do_start(5);
        n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1 || cpu_reset !== 1'b0) begin
            n_err++; $display("FAIL start_in_run: ready %b busy %b cpu_reset %b required 0 1 0", in_ready, busy, cpu_reset); end
        wait_done();
        first_cnt = int'(run_cycles);
        n_cmp++; if (run_cycles !== 32'(16 + HALT_CYC - 1) || timeout !== 1'b0 || wr_addr_q.size() != 0) begin
            n_err++; $display("FAIL rerun_result: run %0d timeout %b writes %0d required %0d 0 0", run_cycles, timeout, wr_addr_q.size(), 16 + HALT_CYC - 1); end
        do_start(0);
        wait_done();
        n_cmp++; if (run_cycles !== 32'(first_cnt)) begin
            n_err++; $display("FAIL rerun_repeat: run %0d required %0d", run_cycles, first_cnt); end
    endtask

    task automatic test_clamp();
        logic [31:0] exp_d[$];
        int bad;
        stick_pc = 32'h10;
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(IMG + 5);
        for (int i = 0; i < IMG; i++) begin
            exp_d.push_back($urandom);
            send_word(exp_d[i], $urandom_range(0, 1));
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clamp_ready: in_ready %b required 0", in_ready); end
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_addr_q.size() != IMG || wr_addr_q[IMG-1] != IMG - 1) begin
            n_err++; $display("FAIL clamp_count: %0d writes required %0d ending at %0d", wr_addr_q.size(), IMG, IMG - 1); end
        bad = 0;
        for (int i = 0; i < IMG && i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] !== exp_d[i]) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clamp_data: %0d bad writes required 0", bad); end
        wait_done();
        n_cmp++; if (in_ready !== 1'b0 || done !== 1'b1) begin
            n_err++; $display("FAIL clamp_end: ready %b done %b required 0 1", in_ready, done); end
    endtask

    task automatic test_tie();
        int cyc; bit tmo;
        stick_pc = 32'(4 * (MAX_RUN - HALT_CYC));
        model_run(longint'(stick_pc), cyc, tmo);
        do_start(0);
        wait_done();
        n_cmp++; if (run_cycles !== 32'(cyc) || timeout !== tmo) begin
            n_err++; $display("FAIL tie_halt: run %0d timeout %b required %0d %b", run_cycles, timeout, cyc, tmo); end
    endtask

    task automatic test_random();
        int cyc, len, bad; bit tmo;
        logic [31:0] exp_d[$];
        for (int it = 0; it < 8; it++) begin
            len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
            stick_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'(4 * $urandom_range(0, 30));
            model_run(longint'(stick_pc), cyc, tmo);
            wr_addr_q.delete(); wr_data_q.delete(); exp_d.delete();
            do_start(len);
            for (int i = 0; i < len; i++) begin
                exp_d.push_back($urandom);
                send_word(exp_d[i], $urandom_range(0, 3));
            end
            wait_done();
            bad = (wr_addr_q.size() != len) ? 1 : 0;
            for (int i = 0; i < len && i < wr_addr_q.size(); i++)
                if (wr_addr_q[i] != i || wr_data_q[i] !== exp_d[i]) bad++;
            n_cmp++; if (bad != 0) begin
                n_err++; $display("FAIL rand%0d_image: %0d bad of %0d writes required 0", it, bad, len); end
            n_cmp++; if (done !== 1'b1 || run_cycles !== 32'(cyc) || timeout !== tmo) begin
                n_err++; $display("FAIL rand%0d_run: done %b run %0d timeout %b required 1 %0d %b", it, done, run_cycles, timeout, cyc, tmo); end
        end
    endtask

    initial begin
        test_reset();
        test_mid_load_reset();
        test_gapped_load();
        test_halt_detect();
        test_timeout();
        test_rerun();
        test_clamp();
        test_tie();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
